// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory signals of the arbiter.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     i_req;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0]    i_rdata;
  logic                     i_valid;

  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     d_valid;

  logic                     m_req;
  logic                     m_we;
  logic [ADDRESS_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0]    m_wdata;
  logic [DATA_WIDTH-1:0]    m_rdata;
  logic                     m_ack;

  logic                     busy;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_valid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_valid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch and data) in front of a single-port memory.
// Data wins ties unless fetch has waited through STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       i_elig;
  logic       d_elig;
  logic       grant_i;
  logic       grant_d;

  // A requester cannot win in the cycle its completion is being reported.
  assign i_elig = bus.i_req & ~bus.i_valid;
  assign d_elig = bus.d_req & ~bus.d_valid;

  assign bus.m_req = (state != IDLE);
  assign bus.busy  = (state != IDLE);

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_elig && (!d_elig || starve_cnt == LIMIT)) begin
          grant_i   = 1'b1;
          state_nxt = I_BUSY;
        end else if (d_elig) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request capture on grant, completion pulses, read-data capture, starvation count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt  <= '0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_valid <= (state == I_BUSY) && bus.m_ack;
      bus.d_valid <= (state == D_BUSY) && bus.m_ack;
      if ((state == I_BUSY) && bus.m_ack) bus.i_rdata <= bus.m_rdata;
      if ((state == D_BUSY) && bus.m_ack) bus.d_rdata <= bus.m_rdata;
      if (grant_i) begin
        bus.m_addr <= bus.i_addr;
        bus.m_we   <= 1'b0;
        starve_cnt <= '0;
      end else if (grant_d) begin
        bus.m_addr  <= bus.d_addr;
        bus.m_we    <= bus.d_we;
        bus.m_wdata <= bus.d_wdata;
        if (!i_elig)                 starve_cnt <= '0;
        else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester tasks push expected completions into
// queues, a monitor pops them on each valid pulse, and a transaction-level
// memory/arbitration model drives m_ack and predicts grants.
module tb_mem_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] i_exp [$];
  logic [32:0] d_exp [$];
  int          grant_log [$];

  int          inflight = 0;      // 0 none, 1 fetch, 2 data
  int unsigned wait_cnt = 0;
  logic [31:0] rec_addr = '0;
  logic [31:0] rec_wdata = '0;
  logic        rec_we = 1'b0;
  logic        exp_ival = 1'b0;
  logic        exp_dval = 1'b0;
  int unsigned starve = 0;
  int unsigned lat_fixed = 0;
  bit          stray_en = 1'b0;
  bit          ack_after_rst = 1'b0;
  bit          rst_seen_low = 1'b0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no completion within budget at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    bit got = 1'b0;
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    i_exp.push_back(mem_rd(a));
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.i_valid || !rst) begin got = 1'b1; break; end
    end
    if (!got) timeout("fetch_wait");
    bus.i_req = 1'b0;
    step();
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    d_exp.push_back({we, we ? 32'h0 : mem_rd(a)});
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.d_valid || !rst) begin got = 1'b1; break; end
    end
    if (!got) timeout("data_wait");
    bus.d_req = 1'b0;
    step();
  endtask

  task automatic fetch_loop(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(maxgap)) step();
      do_fetch(32'h1000 + 4 * $urandom_range(255));
    end
  endtask

  task automatic data_loop(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(maxgap)) step();
      do_data(1'($urandom_range(1)), 4 * $urandom_range(63), $urandom);
    end
  endtask

  // Memory responder and arbitration reference model.
  always @(negedge clk) begin
    logic        elig_i, elig_d, nv_i, nv_d;
    int unsigned lat;
    if (!rst) begin
      inflight     = 0;
      exp_ival     = 1'b0;
      exp_dval     = 1'b0;
      starve       = 0;
      bus.m_ack    = 1'b0;
      bus.m_rdata  = $urandom;
      rst_seen_low = 1'b1;
    end else begin
      chk("m_req", bus.m_req, inflight != 0);
      chk("busy", bus.busy, inflight != 0);
      chk("i_valid", bus.i_valid, exp_ival);
      chk("d_valid", bus.d_valid, exp_dval);
      chk("starve_cnt", dut.starve_cnt, starve);
      if (inflight != 0) begin
        chk("m_addr", bus.m_addr, rec_addr);
        chk("m_we", bus.m_we, rec_we);
        if (rec_we) chk("m_wdata", bus.m_wdata, rec_wdata);
      end
      elig_i      = bus.i_req && !exp_ival;
      elig_d      = bus.d_req && !exp_dval;
      nv_i        = 1'b0;
      nv_d        = 1'b0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
      if (inflight != 0) begin
        if (wait_cnt == 0) begin
          bus.m_ack = 1'b1;
          if (inflight == 1) begin
            bus.m_rdata = mem_rd(rec_addr);
            nv_i = 1'b1;
          end else begin
            if (rec_we) mem[rec_addr] = rec_wdata;
            else        bus.m_rdata = mem_rd(rec_addr);
            nv_d = 1'b1;
          end
          inflight = 0;
        end else begin
          wait_cnt--;
        end
      end else begin
        if ((stray_en && $urandom_range(3) == 0) || (ack_after_rst && rst_seen_low)) begin
          bus.m_ack     = 1'b1;
          ack_after_rst = 1'b0;
        end
        lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        if (elig_i && (!elig_d || starve == LIMIT)) begin
          inflight = 1; rec_addr = bus.i_addr; rec_we = 1'b0;
          starve = 0; wait_cnt = lat; grant_log.push_back(1);
        end else if (elig_d) begin
          inflight = 2; rec_addr = bus.d_addr; rec_we = bus.d_we; rec_wdata = bus.d_wdata;
          starve = elig_i ? ((starve < LIMIT) ? starve + 1 : starve) : 0;
          wait_cnt = lat; grant_log.push_back(2);
        end
      end
      exp_ival     = nv_i;
      exp_dval     = nv_d;
      rst_seen_low = 1'b0;
    end
  end

  // Scoreboard monitor: pops expected read data on each completion pulse.
  always @(negedge clk) begin
    logic [31:0] ei;
    logic [32:0] ed;
    if (!rst) begin
      last_i = '0;
      last_d = '0;
    end else begin
      if (bus.i_valid) begin
        if (i_exp.size() == 0) chk("i_valid_unexpected", bus.i_valid, 1'b0);
        else begin
          ei = i_exp.pop_front();
          chk("i_rdata", bus.i_rdata, ei);
        end
        last_i = bus.i_rdata;
      end else chk("i_rdata_hold", bus.i_rdata, last_i);
      if (bus.d_valid) begin
        if (d_exp.size() == 0) chk("d_valid_unexpected", bus.d_valid, 1'b0);
        else begin
          ed = d_exp.pop_front();
          if (!ed[32]) chk("d_rdata", bus.d_rdata, ed[31:0]);
        end
        last_d = bus.d_rdata;
      end else chk("d_rdata_hold", bus.d_rdata, last_d);
    end
  end

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_m_we", bus.m_we, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_i_valid", bus.i_valid, 1'b0);
    chk("rst_d_valid", bus.d_valid, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_starve", dut.starve_cnt, 4'd0);
    step();
    rst = 1'b1;
    step();

    mem[32'h100] = 32'hDEADBEEF;
    lat_fixed = 2;
    do_fetch(32'h100);
    chk("fetch_rdata", bus.i_rdata, 32'hDEADBEEF);

    do_data(1'b1, 32'h40, 32'h12345678);
    do_data(1'b0, 32'h40, 32'h0);
    chk("store_readback", bus.d_rdata, 32'h12345678);
    lat_fixed = 0;

    repeat (2) step();
    grant_log.delete();
    fork
      do_fetch(32'h1200);
      do_data(1'b0, 32'h44, 32'h0);
    join
    chk("simul_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("simul_first_data", grant_log[0], 2);
      chk("simul_second_fetch", grant_log[1], 1);
    end
    chk("simul_starve_clear", dut.starve_cnt, 4'd0);

    fork
      fetch_loop(12, 0);
      data_loop(12, 0);
    join

    lat_fixed = 8;
    bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
    repeat (3) step();
    chk("midop_busy", bus.busy, 1'b1);
    rst = 1'b0;
    bus.d_req = 1'b0;
    ack_after_rst = 1'b1;
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("midop_m_req", bus.m_req, 1'b0);
    chk("midop_busy_clear", bus.busy, 1'b0);
    chk("midop_no_commit", mem.exists(32'h80), 1'b0);
    lat_fixed = 0;

    stray_en = 1'b1;
    repeat (12) step();
    fork
      fetch_loop(40, 4);
      data_loop(40, 4);
    join
    stray_en = 1'b0;
    repeat (5) step();
    chk("i_exp_drained", i_exp.size(), 0);
    chk("d_exp_drained", d_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: bench did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all data buses.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32: width of all address buses.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants issued while a fetch request is waiting; legal range 1..15.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- i_req  in  1  fetch-side request.
- i_addr  in  ADDRESS_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetch read data.
- i_valid  out  1  fetch completion pulse.
- d_req  in  1  data-side request.
- d_we  in  1  data-side write enable; 1 = store, 0 = load.
- d_addr  in  ADDRESS_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data.
- d_valid  out  1  data completion pulse.
- m_req  out  1  request to the shared single-port memory.
- m_we  out  1  memory write enable.
- m_addr  out  ADDRESS_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_rdata  in  DATA_WIDTH  memory read data; valid in the cycle m_ack is high.
- m_ack  in  1  memory completion pulse; one cycle long, any latency of 1 or more cycles after m_req rises.
- busy  out  1  high while a memory transaction is outstanding.

Function
REQ-005 SHALL implement an FSM with states IDLE, I_BUSY and D_BUSY.
REQ-006 Eligibility in IDLE: i_req is eligible only when i_valid is low, and d_req is eligible only when d_valid is low. This prevents re-granting a requester in the cycle its completion is reported.
REQ-007 In IDLE, when exactly one requester is eligible, the FSM SHALL move to that requester's BUSY state on the next edge.
REQ-008 In IDLE, when both are eligible, the FSM SHALL go to D_BUSY unless starve_cnt == STARVE_LIMIT, in which case it SHALL go to I_BUSY.
REQ-009 On each grant, the FSM SHALL register the winner's address, and for data grants also d_we and d_wdata. m_addr, m_we and m_wdata SHALL come from these registers and hold stable for the whole transaction.
REQ-010 m_req SHALL be high in I_BUSY and D_BUSY and low in IDLE.
REQ-011 m_we SHALL be 0 for fetch transactions.
REQ-012 In a BUSY state with m_ack high, the FSM SHALL return to IDLE on the next edge. There is no same-cycle re-grant, so transactions are always separated by at least one IDLE cycle.
REQ-013 In the cycle after m_ack in I_BUSY, i_valid SHALL pulse high for exactly 1 cycle, with i_rdata = the registered m_rdata.
REQ-014 In the cycle after m_ack in D_BUSY, d_valid SHALL pulse high for exactly 1 cycle, with d_rdata = the registered m_rdata. For stores, d_rdata is don't-care.
REQ-015 i_rdata and d_rdata SHALL hold their last value between completions.
REQ-016 m_ack received in IDLE SHALL be ignored: no state change, no valid pulse.
REQ-017 Requesters SHALL hold req, addr and wdata stable until their valid pulse, and deassert req in the valid cycle or later. Requests dropped before completion are not aborted; the transaction still completes and pulses valid.
REQ-018 starve_cnt is a 4-bit counter with the following rules:
- Increment on a D_BUSY grant while i_req is eligible, saturating at STARVE_LIMIT.
- Clear to 0 on any I_BUSY grant.
- Clear to 0 on a D_BUSY grant while i_req is not eligible.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 Total latency SHALL be grant edge -> m_req high (1 cycle after eligible request), then m_ack -> valid (1 cycle). Minimum request-to-valid latency with a 1-cycle memory is 3 cycles.

Reset
REQ-021 When rst is low at a rising edge, the block SHALL set:
- state = IDLE
- starve_cnt = 0
- m_req = 0, m_we = 0, m_addr = 0, m_wdata = 0
- i_valid = 0, d_valid = 0
- i_rdata = 0, d_rdata = 0
- busy = 0
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction without a valid pulse. Any m_ack arriving after reset is ignored per REQ-016.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Single fetch: i_req=1, i_addr=0x100, memory ack after 2 cycles with m_rdata=0xDEADBEEF -> m_addr=0x100, m_we=0, one i_valid pulse, i_rdata=0xDEADBEEF, d_valid never high.
- Single store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> m_we=1, m_addr=0x40, m_wdata=0x12345678, one d_valid pulse.
- Simultaneous requests with starve_cnt=0: i_req and d_req rise in the same cycle -> data served first, then fetch after one IDLE cycle; starve_cnt = 0 after the fetch grant.
- Starvation guard, STARVE_LIMIT=4: d_req held continuously with i_req held -> exactly 4 data transactions, then a fetch grant, then data resumes.
- Reset mid-op: rst low in D_BUSY before m_ack, m_ack arrives one cycle after release -> no d_valid, m_req=0, state IDLE, busy=0.
- Stray ack: m_ack pulsed in IDLE with no requests -> all outputs unchanged, no valid pulse.
